// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the MEM/WB stage and neighbouring pipeline registers.
package mem_wb_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Fields carried into the writeBack stage.
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [DATA_W-1:0]     alu_out;
        logic [REG_ADDR_W-1:0] write_reg;
    } wb_ctrl_t;

    // Snapshot of an issued memory instruction, held while waiting for ack.
    typedef struct packed {
        logic                  store;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [DATA_W-1:0]     addr;
        logic [DATA_W-1:0]     wdata;
        logic [REG_ADDR_W-1:0] wreg;
    } txn_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Request/acknowledge data-memory port between the MEM stage and data memory.
interface mem_wb_stage_if;
    import mem_wb_stage_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register with bubble insertion; read data and fault flags load separately.
module mem_wb_reg
    import mem_wb_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble_i,
    input  wb_ctrl_t          wb_i,
    input  logic              rdata_en_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              misalign_i,
    input  logic              bus_err_i,
    output wb_ctrl_t          wb_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              misalign_o,
    output logic              bus_err_o
);

    wb_ctrl_t          wb_d, wb_q;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              misalign_q, bus_err_q;

    always_comb begin
        wb_d = wb_i;
        // A bubble kills the write but leaves the data fields as they were.
        if (bubble_i) begin
            wb_d            = wb_q;
            wb_d.reg_write  = 1'b0;
            wb_d.mem_to_reg = 1'b0;
        end
        rdata_d = rdata_en_i ? rdata_i : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q       <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            wb_q       <= wb_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_i;
            bus_err_q  <= bus_err_i;
        end
    end

    assign wb_o       = wb_q;
    assign rdata_o    = rdata_q;
    assign misalign_o = misalign_q;
    assign bus_err_o  = bus_err_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage: issues word loads/stores on a req/ack port, stalls upstream while
// waiting, aborts after MAX_WAIT request cycles, and feeds the MEM/WB register.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ValidM,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic                  MemWriteM,
    input  logic [DATA_W-1:0]     ALUOutM,
    input  logic [DATA_W-1:0]     WriteDataM,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    output logic                  StallM,
    mem_wb_stage_if.master        mem,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic [DATA_W-1:0]     ALUOutW,
    output logic [DATA_W-1:0]     ReadDataW,
    output logic [REG_ADDR_W-1:0] WriteRegW,
    output logic                  MisalignW,
    output logic                  BusErrW
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    txn_t             txn_q, txn_d;
    txn_t             m_txn, cur;

    logic     mem_op;
    logic     req, stall, complete, abort, misalign;
    logic     bubble, rdata_en;
    wb_ctrl_t wb_in, wb_out;

    assign mem_op = ValidM & (MemtoRegM | MemWriteM);
    assign m_txn  = '{store:      MemWriteM,
                      reg_write:  RegWriteM,
                      mem_to_reg: MemtoRegM,
                      addr:       ALUOutM,
                      wdata:      WriteDataM,
                      wreg:       WriteRegM};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        txn_d    = txn_q;
        cur      = m_txn;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        misalign = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (ALUOutM[1:0] != 2'b00) begin
                        misalign = 1'b1;
                    end else begin
                        req   = 1'b1;
                        txn_d = m_txn;
                        if (mem.mem_ack) begin
                            complete = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            state_d = WAIT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
            end
            WAIT: begin
                // Upstream inputs are ignored here; the captured copy drives everything.
                cur = txn_q;
                req = 1'b1;
                if (mem.mem_ack) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_in.reg_write  = complete ? (cur.reg_write & ~cur.store) : (ValidM & RegWriteM);
        wb_in.mem_to_reg = complete & cur.mem_to_reg;
        wb_in.alu_out    = cur.addr;
        wb_in.write_reg  = cur.wreg;
        bubble           = stall | abort | misalign;
        rdata_en         = complete & ~cur.store;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txn_q   <= txn_d;
        end
    end

    // Reset must drop the request and stall immediately, not at the next edge.
    assign mem.mem_req   = req & rst_n;
    assign StallM        = stall & rst_n;
    assign mem.mem_we    = cur.store;
    assign mem.mem_addr  = cur.addr;
    assign mem.mem_wdata = cur.wdata;

    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .bubble_i   (bubble),
        .wb_i       (wb_in),
        .rdata_en_i (rdata_en),
        .rdata_i    (mem.mem_rdata),
        .misalign_i (misalign),
        .bus_err_i  (abort),
        .wb_o       (wb_out),
        .rdata_o    (ReadDataW),
        .misalign_o (MisalignW),
        .bus_err_o  (BusErrW)
    );

    assign RegWriteW = wb_out.reg_write;
    assign MemtoRegW = wb_out.mem_to_reg;
    assign ALUOutW   = wb_out.alu_out;
    assign WriteRegW = wb_out.write_reg;

endmodule
